// File: rtl/firebird7_in_gate1_tessent_capture_pkg.sv
// Shared constants, scan-register field layout and helpers for the gate1 IJTAG capture TDR.
package firebird7_in_gate1_tessent_capture_pkg;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SR_W   = DATA_W + CNT_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned CNT_LSB  = DATA_W;
  localparam int unsigned CLR_BIT  = SR_W - 1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CAPTURE,
    OP_SHIFT
  } op_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset to zero.
module firebird7_in_gate1_tessent_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1_q, stage1_d;
  logic [W-1:0] stage2_q, stage2_d;

  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_capture_w19.sv
// IJTAG capture TDR: snapshots a 19-bit bus plus a saturating capture count onto a 23-bit scan chain.
// Define FIREBIRD7_IN_CAPTURE_SYNC_EN to insert a 2-flop synchronizer on the observed bus.
module firebird7_in_gate1_tessent_data_capture_w19
  import firebird7_in_gate1_tessent_capture_pkg::*;
(
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  input  logic [DATA_W-1:0] functional_data_in,
  output logic              ijtag_so,
  output logic [CNT_W-1:0]  capture_count
);

  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_s;
  op_e               op;
  logic              upd_clr;

`ifdef FIREBIRD7_IN_CAPTURE_SYNC_EN
  firebird7_in_gate1_tessent_sync2 #(
    .W(DATA_W)
  ) u_sync (
    .clk(ijtag_tck),
    .rst(ijtag_reset),
    .d  (functional_data_in),
    .q  (data_s)
  );
`else
  always_comb data_s = functional_data_in;
`endif

  // Capture dominates; update looks at the pre-shift clear bit even when shifting.
  always_comb begin
    op = OP_HOLD;
    if (ijtag_sel) begin
      if (ijtag_ce)      op = OP_CAPTURE;
      else if (ijtag_se) op = OP_SHIFT;
    end
    upd_clr = ijtag_sel & ~ijtag_ce & ijtag_ue & sr_q[CLR_BIT];
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    unique case (op)
      OP_CAPTURE: begin
        sr_d[DATA_LSB +: DATA_W] = data_s;
        sr_d[CNT_LSB +: CNT_W]   = cnt_q;
        cnt_d                    = sat_inc(cnt_q);
      end
      OP_SHIFT: sr_d = {ijtag_si, sr_q[SR_W-1:1]};
      default: ;
    endcase
    if (upd_clr) cnt_d = '0;
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ijtag_so      = sr_q[0];
  assign capture_count = cnt_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_capture_w19.sv
// Randomized + directed bench; the reference model keeps the scan chain as a bit queue (front = scan out).
module tb_firebird7_in_gate1_tessent_data_capture_w19;

  logic        tck = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic [18:0] fdi = '0;
  logic        so;
  logic [3:0]  cc;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_capture_w19 dut (
    .ijtag_tck         (tck),
    .ijtag_reset       (rst),
    .ijtag_sel         (sel),
    .ijtag_ce          (ce),
    .ijtag_se          (se),
    .ijtag_ue          (ue),
    .ijtag_si          (si),
    .functional_data_in(fdi),
    .ijtag_so          (so),
    .capture_count     (cc)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit          mq[$];
  int unsigned m_cnt;
  logic [18:0] hist[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    repeat (23) mq.push_back(1'b0);
    m_cnt = 0;
    hist.delete();
  endfunction

  task automatic tick(input logic s, input logic c, input logic sh, input logic u,
                      input logic si_v, input logic [18:0] d);
    logic [18:0] ds;
    bit          clr;
    sel = s; ce = c; se = sh; ue = u; si = si_v; fdi = d;
    @(posedge tck);
`ifdef FIREBIRD7_IN_CAPTURE_SYNC_EN
    ds = (hist.size() >= 2) ? hist[$-1] : '0;
`else
    ds = d;
`endif
    hist.push_back(d);
    if (hist.size() > 4) void'(hist.pop_front());
    if (s && c) begin
      mq.delete();
      for (int k = 0; k < 19; k++) mq.push_back(ds[k]);
      for (int k = 0; k < 4; k++)  mq.push_back(m_cnt[k]);
      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end else if (s) begin
      clr = u && mq[22];
      if (sh) begin
        void'(mq.pop_front());
        mq.push_back(si_v);
      end
      if (clr) m_cnt = 0;
    end
    #1;
    check_eq("so", so, mq[0]);
    check_eq("capture_count", cc, m_cnt);
  endtask

  task automatic idle(input logic [18:0] d);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic capture_data(input logic [18:0] d);
    idle(d);
    idle(d);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic readout(output logic [22:0] w);
    for (int k = 0; k < 23; k++) begin
      w[k] = so;
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom_range(1)), fdi);
    end
  endtask

  task automatic clear_cnt();
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, fdi);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fdi);
  endtask

  logic [22:0] w;
  logic [18:0] pat[3];

  initial begin
    model_reset();
    repeat (2) @(posedge tck);
    #1;
    check_eq("reset_so", so, 1'b0);
    check_eq("reset_cnt", cc, 4'h0);
    rst = 1'b0;

    // Reset in the middle of a shift
    capture_data(19'h7FFFF);
    repeat (5) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, fdi);
    rst = 1'b1;
    #2;
    check_eq("midshift_rst_so", so, 1'b0);
    check_eq("midshift_rst_cnt", cc, 4'h0);
    model_reset();
    rst = 1'b0;
    #1;
    capture_data(19'h5A5A5);
    readout(w);
    check_eq("readout_5a5a5", w, {4'h0, 19'h5A5A5});

    // Three passes: count field reads 0,1,2
    clear_cnt();
    check_eq("clear", cc, 4'h0);
    pat[0] = 19'h00001; pat[1] = 19'h7FFFF; pat[2] = 19'h2AAAA;
    for (int p = 0; p < 3; p++) begin
      capture_data(pat[p]);
      readout(w);
      check_eq("pass_word", w, {4'(p), pat[p]});
    end
    check_eq("pass_count", cc, 4'd3);

    // Saturation
    clear_cnt();
    repeat (16) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h01234);
    check_eq("sat_16", cc, 4'd15);
    capture_data(19'h00123);
    readout(w);
    check_eq("sat_field", w, {4'd15, 19'h00123});
    check_eq("sat_17", cc, 4'd15);

    // Update with 0 in the clear bit leaves the count alone
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, fdi);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fdi);
    check_eq("no_clear", cc, 4'd15);
    clear_cnt();
    check_eq("clear2", cc, 4'h0);

    // ce with se: capture wins
    idle(19'h3C3C3);
    idle(19'h3C3C3);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'h3C3C3);
    readout(w);
    check_eq("ce_over_se", w, {4'h0, 19'h3C3C3});

    // Deselected: hold regardless of ce/se/ue
    for (int k = 0; k < 10; k++)
      tick(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 19'($urandom));
    check_eq("sel0_hold_cnt", cc, 4'd1);

    // Observation latency
    repeat (3) idle(19'h0);
    idle(19'h12345);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h12345);
    readout(w);
`ifdef FIREBIRD7_IN_CAPTURE_SYNC_EN
    check_eq("late_change", w[18:0], 19'h0);
`else
    check_eq("late_change", w[18:0], 19'h12345);
`endif
    repeat (3) idle(19'h0);
    capture_data(19'h12345);
    readout(w);
    check_eq("early_change", w[18:0], 19'h12345);

    // Random traffic against the model
    for (int k = 0; k < 600; k++)
      tick(($urandom_range(7) != 0), ($urandom_range(5) == 0), 1'($urandom_range(1)),
           ($urandom_range(3) == 0), 1'($urandom_range(1)), 19'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
